// File: rtl/lsu.sv
// ============================================================================
//  Module   : lsu
//  Purpose  : Memory stage that runs one bus transaction per load/store and
//             passes ALU results through to the W-stage.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lsu #(
    parameter int XLEN = 32,
    parameter int AW   = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            M_valid_i,
    output logic            m_ready_o,
    input  logic            is_load_i,
    input  logic            is_store_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] res_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [31:0]     mem_wdata_o,
    output logic [3:0]      mem_wstrb_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [31:0]     mem_rdata_i,
    output logic            m_valid_o,
    input  logic            W_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            exc_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic              is_load_q, is_load_d;
    logic              is_store_q, is_store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              exc_q, exc_d;

    logic              w_accept;
    logic              w_is_mem;
    logic              w_illegal;
    logic              w_misaligned;
    logic [31:0]       w_shifted;
    logic [XLEN-1:0]   w_load_val;

    assign m_ready_o = (state_q == S_IDLE) | ((state_q == S_DONE) & W_ready_i);
    assign w_accept  = M_valid_i & m_ready_o;

    assign w_is_mem     = is_load_i | is_store_i;
    assign w_illegal    = (is_load_i & is_store_i) | (funct3_i == 3'b011)
                        | (funct3_i[2:1] == 2'b11) | (is_store_i & funct3_i[2]);
    assign w_misaligned = ((funct3_i[1:0] == 2'b01) & res_i[0])
                        | ((funct3_i[1:0] == 2'b10) & (res_i[1:0] != 2'b00));

    // Bus fields come straight from the captured request so they stay stable until grant.
    assign mem_req_o  = (state_q == S_REQ);
    assign mem_we_o   = is_store_q;
    assign mem_addr_o = {addr_q[AW-1:2], 2'b00};

    always_comb begin
        mem_wstrb_o = 4'b0000;
        mem_wdata_o = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                mem_wstrb_o = 4'b0001 << addr_q[1:0];
                mem_wdata_o = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                mem_wstrb_o = 4'b0011 << addr_q[1:0];
                mem_wdata_o = {2{wdata_q[15:0]}};
            end
            default: mem_wstrb_o = 4'b1111;
        endcase
        if (!is_store_q) begin
            mem_wstrb_o = 4'b0000;
        end
    end

    assign w_shifted = mem_rdata_i >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  w_load_val = XLEN'($signed(w_shifted[7:0]));
            3'b100:  w_load_val = XLEN'(w_shifted[7:0]);
            3'b001:  w_load_val = XLEN'($signed(w_shifted[15:0]));
            3'b101:  w_load_val = XLEN'(w_shifted[15:0]);
            default: w_load_val = XLEN'($signed(w_shifted));
        endcase
    end

    always_comb begin
        state_d    = state_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        res_d      = res_q;
        exc_d      = exc_q;

        case (state_q)
            S_REQ: begin
                if (mem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d = S_DONE;
                    res_d   = is_load_q ? w_load_val : '0;
                    exc_d   = 1'b0;
                end
            end
            S_DONE: begin
                if (W_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: ;
        endcase

        // An accept in DONE overrides the return to IDLE, giving zero-bubble issue.
        if (w_accept) begin
            is_load_d  = is_load_i;
            is_store_d = is_store_i;
            funct3_d   = funct3_i;
            addr_d     = res_i[AW-1:0];
            wdata_d    = wdata_i[31:0];
            res_d      = res_i;
            if (!w_is_mem) begin
                state_d = S_DONE;
                exc_d   = 1'b0;
            end else if (w_illegal | w_misaligned) begin
                state_d = S_DONE;
                exc_d   = 1'b1;
            end else begin
                state_d = S_REQ;
                exc_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            res_q      <= '0;
            exc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            res_q      <= res_d;
            exc_q      <= exc_d;
        end
    end

    assign m_valid_o = (state_q == S_DONE);
    assign res_o     = res_q;
    assign exc_o     = exc_q;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
//  Module   : tb_lsu
//  Purpose  : Self-checking bench for lsu against a byte-level reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_lsu;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        M_valid_i;
    logic        m_ready_o;
    logic        is_load_i;
    logic        is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] res_i;
    logic [31:0] wdata_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        m_valid_o;
    logic        W_ready_i;
    logic [31:0] res_o;
    logic        exc_o;

    int n_tests = 0;
    int n_fail  = 0;

    lsu #(.XLEN(32), .AW(32)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .M_valid_i   (M_valid_i),
        .m_ready_o   (m_ready_o),
        .is_load_i   (is_load_i),
        .is_store_i  (is_store_i),
        .funct3_i    (funct3_i),
        .res_i       (res_i),
        .wdata_i     (wdata_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wstrb_o (mem_wstrb_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .m_valid_o   (m_valid_o),
        .W_ready_i   (W_ready_i),
        .res_o       (res_o),
        .exc_o       (exc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: access size in bytes, lane offset, mask/extend by arithmetic.
    task automatic model(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         output bit mem, output bit exc, output logic [31:0] res,
                         output logic [3:0] strb, output logic [31:0] bw);
        int size, off;
        logic [31:0] mask, v;
        size = 1 << f3[1:0];
        off  = int'(a % 4);
        exc  = 1'b0;
        if (ld && st) exc = 1'b1;
        if (ld || st) begin
            if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) exc = 1'b1;
            if (st && f3 >= 3'd4) exc = 1'b1;
            if (size > 1 && (a % size) != 0) exc = 1'b1;
        end
        mem  = (ld || st) && !exc;
        res  = a;
        strb = 4'b0000;
        bw   = 32'h0;
        if (mem) begin
            if (st) begin
                strb = 4'((1 << size) - 1) << off;
                for (int i = 0; i < 4; i++) bw[8*i +: 8] = wd[8*(i % size) +: 8];
                res = 32'h0;
            end else begin
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 32'd1);
                v    = (rd >> (8*off)) & mask;
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
                res = v;
            end
        end
    endtask

    task automatic scramble();
        is_load_i  = 1'($urandom);
        is_store_i = 1'($urandom);
        funct3_i   = 3'($urandom);
        res_i      = $urandom;
        wdata_i    = $urandom;
    endtask

    // Called at a negedge with the DUT ready; returns at a negedge in IDLE.
    task automatic do_instr(input bit ld, input bit st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                            input int gd, input int rdly, input int wdly);
        bit mem, exc;
        logic [31:0] eres, ebw;
        logic [3:0]  estrb;
        model(ld, st, f3, a, wd, rd, mem, exc, eres, estrb, ebw);
        chk("ready_accept", m_ready_o, 1);
        M_valid_i = 1; is_load_i = ld; is_store_i = st; funct3_i = f3;
        res_i = a; wdata_i = wd; W_ready_i = 0;
        @(negedge clk_i);
        M_valid_i = 0;
        scramble();
        if (mem) begin
            for (int i = 0; i <= gd; i++) begin
                chk("req", mem_req_o, 1);
                chk("we", mem_we_o, st);
                chk("addr", mem_addr_o, {a[31:2], 2'b00});
                chk("wstrb", mem_wstrb_o, estrb);
                if (st) chk("wdata", mem_wdata_o, ebw);
                chk("ready_busy", m_ready_o, 0);
                mem_gnt_i = (i == gd);
                @(negedge clk_i);
            end
            mem_gnt_i = 0;
            for (int i = 0; i <= rdly; i++) begin
                chk("req_wait", mem_req_o, 0);
                chk("valid_wait", m_valid_o, 0);
                mem_rvalid_i = (i == rdly);
                mem_rdata_i  = (i == rdly) ? rd : $urandom;
                @(negedge clk_i);
            end
            mem_rvalid_i = 0;
            mem_rdata_i  = $urandom;
        end
        for (int i = 0; i <= wdly; i++) begin
            chk("valid_done", m_valid_o, 1);
            chk("res", res_o, eres);
            chk("exc", exc_o, exc);
            chk("ready_done", m_ready_o, 0);
            chk("req_done", mem_req_o, 0);
            W_ready_i = (i == wdly);
            M_valid_i = (i < wdly);
            @(negedge clk_i);
            scramble();
        end
        M_valid_i = 0;
        chk("valid_idle", m_valid_o, 0);
        chk("req_idle", mem_req_o, 0);
    endtask

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, prev;
        int kind, size;
        rst_n_i = 0; M_valid_i = 0; is_load_i = 0; is_store_i = 0; funct3_i = 0;
        res_i = 0; wdata_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; W_ready_i = 0;
        repeat (2) @(negedge clk_i);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_req", mem_req_o, 0);
        chk("rst_res", res_o, 0);
        chk("rst_exc", exc_o, 0);
        rst_n_i = 1;
        @(negedge clk_i);
        chk("rst_ready", m_ready_o, 1);

        // Back-to-back ALU passthrough
        W_ready_i = 1;
        prev = 32'h1234_5678;
        for (int k = 0; k < 8; k++) begin
            M_valid_i = 1; is_load_i = 0; is_store_i = 0; funct3_i = 3'($urandom);
            a = (k == 0) ? 32'h1234_5678 : $urandom;
            res_i = a;
            @(negedge clk_i);
            chk("b2b_valid", m_valid_o, 1);
            chk("b2b_res", res_o, a);
            chk("b2b_exc", exc_o, 0);
            chk("b2b_req", mem_req_o, 0);
            chk("b2b_ready", m_ready_o, 1);
            prev = a;
        end
        M_valid_i = 0;
        @(negedge clk_i);
        chk("b2b_idle", m_valid_o, 0);

        // Directed cases
        do_instr(1, 0, 3'b000, 32'h8000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0);
        do_instr(1, 0, 3'b100, 32'h8000_0003, 32'h0, 32'h80FF_0000, 1, 1, 0);
        do_instr(1, 0, 3'b101, 32'h8000_0002, 32'h0, 32'h80FF_0000, 0, 2, 1);
        do_instr(0, 1, 3'b001, 32'h0000_0102, 32'hAAAA_BEEF, 32'h0, 0, 0, 0);
        do_instr(0, 1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 5, 1, 0);
        do_instr(1, 0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 0, 0, 0);
        do_instr(1, 0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0, 0, 0);
        do_instr(0, 1, 3'b100, 32'h0000_1000, 32'h0, 32'h0, 0, 0, 0);
        do_instr(1, 1, 3'b010, 32'h0000_1000, 32'h0, 32'h0, 0, 0, 0);
        do_instr(1, 0, 3'b001, 32'h0000_0010, 32'h0, 32'h1234_F00D, 0, 0, 3);

        // Reset while waiting for the response
        M_valid_i = 1; is_load_i = 1; is_store_i = 0; funct3_i = 3'b010; res_i = 32'h40; W_ready_i = 0;
        @(negedge clk_i);
        M_valid_i = 0; mem_gnt_i = 1;
        chk("rstw_req", mem_req_o, 1);
        @(negedge clk_i);
        mem_gnt_i = 0;
        chk("rstw_wait", mem_req_o, 0);
        rst_n_i = 0;
        @(negedge clk_i);
        chk("rstw_valid", m_valid_o, 0);
        chk("rstw_req2", mem_req_o, 0);
        chk("rstw_ready", m_ready_o, 1);
        chk("rstw_res", res_o, 0);
        rst_n_i = 1;
        @(negedge clk_i);

        // Randomized mix
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            f3 = ($urandom_range(0, 9) < 8) ? 3'(($urandom_range(0, 4) == 3) ? 4 : $urandom_range(0, 2))
                                            : 3'($urandom);
            if (f3 == 3'd3 && $urandom_range(0, 1) == 1) f3 = 3'd5;
            size = 1 << f3[1:0];
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a = a & ~(32'(size) - 32'd1);
            do_instr(kind >= 3 && kind <= 5 || kind == 9, kind >= 6, f3, a, $urandom, $urandom,
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
